// File: rtl/zrb_uart_tx_queue_pkg.sv
// Shared encodings for the UART transmit queue and the transmitter it feeds.
package zrb_uart_tx_queue_pkg;

  // The transmitter consumes exactly one byte per frame.
  localparam int unsigned ByteWidth = 8;

  // Queue launch sequencer.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitDone = 2'd2
  } q_state_e;

  // zrb_uart_tx frame states; ready is high in TxIdle and TxStopBit.
  typedef enum logic [1:0] {
    TxIdle     = 2'd0,
    TxStartBit = 2'd1,
    TxDataSend = 2'd2,
    TxStopBit  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/zrb_uart_tx_queue_if.sv
// Producer/transmitter-side bundle of the UART transmit queue.
interface zrb_uart_tx_queue_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  clr_ovf;
  logic                  tx_ready;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  busy;

  // Environment side: producer plus the transmitter's ready.
  modport master (
    output wr_en, data_in, clr_ovf, tx_ready,
    input  tx_start, tx_data, fifo_full, fifo_empty, count, overflow, busy
  );

  // Queue side.
  modport slave (
    input  wr_en, data_in, clr_ovf, tx_ready,
    output tx_start, tx_data, fifo_full, fifo_empty, count, overflow, busy
  );
endinterface

// File: rtl/zrb_sync_fifo.sv
// Single-clock FIFO with synchronous reset and a combinational head read.
module zrb_sync_fifo #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned PtrW  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  do_wr, do_rd;

  // Status from the registered pointers; the extra pointer bit separates full from empty.
  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    fifo_full  = (count == PtrW'(Depth));
    fifo_empty = (count == '0);
    do_wr      = wr_en & ~fifo_full;
    do_rd      = rd_en & ~fifo_empty;
    wr_ptr_d   = do_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = do_rd ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    data_out   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents survive reset since the pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/zrb_uart_tx_queue.sv
// Byte queue feeding zrb_uart_tx one frame at a time from its ready handshake.
module zrb_uart_tx_queue
  import zrb_uart_tx_queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  zrb_uart_tx_queue_if.slave bus
);
  q_state_e              state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  overflow_q, overflow_d;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_full, fifo_empty;
  logic [ADDR_WIDTH:0]   count;

  zrb_sync_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.wr_en),
    .data_in   (bus.data_in),
    .rd_en     (pop),
    .data_out  (head),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .count     (count)
  );

  // Launch sequencer: a launch is only decided on ready so the pulse lands in transmitter idle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && bus.tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = head;
          pop        = 1'b1;
          state_d    = StLaunch;
        end
      end
      StLaunch:   state_d = StWaitDone;
      // Ready here means the transmitter reached its stop bit.
      StWaitDone: if (bus.tx_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Sticky overflow; a dropped write in the same cycle as a clear wins.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.clr_ovf) overflow_d = 1'b0;
    if (bus.wr_en && fifo_full) overflow_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.count      = count;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_zrb_uart_tx_queue.sv
// Bench: two queues (depth 16 and depth 4) on shared stimulus, each driving a transmitter model.
module tb_zrb_uart_tx_queue;
  import zrb_uart_tx_queue_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] data_in = 8'h00;

  always #5 clk = ~clk;

  zrb_uart_tx_queue_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus0 ();
  zrb_uart_tx_queue_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus1 ();

  zrb_uart_tx_queue #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  zrb_uart_tx_queue #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  logic       tx_start_v [2];
  logic [7:0] tx_dat     [2];
  logic [4:0] cnt        [2];
  logic       full_v     [2];
  logic       empty_v    [2];
  logic       ovf_v      [2];
  logic       busy_v     [2];
  logic       tx_rdy     [2];
  logic       ser        [2];

  assign bus0.wr_en = wr_en;     assign bus1.wr_en = wr_en;
  assign bus0.data_in = data_in; assign bus1.data_in = data_in;
  assign bus0.clr_ovf = clr_ovf; assign bus1.clr_ovf = clr_ovf;
  assign bus0.tx_ready = tx_rdy[0];
  assign bus1.tx_ready = tx_rdy[1];
  assign tx_start_v[0] = bus0.tx_start;   assign tx_start_v[1] = bus1.tx_start;
  assign tx_dat[0] = bus0.tx_data;        assign tx_dat[1] = bus1.tx_data;
  assign cnt[0] = bus0.count;             assign cnt[1] = {2'b00, bus1.count};
  assign full_v[0] = bus0.fifo_full;      assign full_v[1] = bus1.fifo_full;
  assign empty_v[0] = bus0.fifo_empty;    assign empty_v[1] = bus1.fifo_empty;
  assign ovf_v[0] = bus0.overflow;        assign ovf_v[1] = bus1.overflow;
  assign busy_v[0] = bus0.busy;           assign busy_v[1] = bus1.busy;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Transmitter model (no reset, like zrb_uart_tx): start, 8 data bits LSB first, stop.
  tx_state_e  tx_st  [2] = '{TxIdle, TxIdle};
  logic [7:0] tx_sh  [2] = '{8'h00, 8'h00};
  logic [2:0] tx_bit [2] = '{3'd0, 3'd0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      case (tx_st[i])
        TxIdle: if (tx_start_v[i] === 1'b1) begin
          tx_st[i] <= TxStartBit;
          tx_sh[i] <= tx_dat[i];
        end
        TxStartBit: begin
          tx_st[i]  <= TxDataSend;
          tx_bit[i] <= 3'd0;
        end
        TxDataSend: begin
          if (tx_bit[i] == 3'd7) tx_st[i] <= TxStopBit;
          tx_bit[i] <= tx_bit[i] + 3'd1;
        end
        default: tx_st[i] <= TxIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tx_rdy[i] = !hold && (tx_st[i] == TxIdle || tx_st[i] == TxStopBit);
      ser[i]    = 1'b1;
      if (tx_st[i] == TxStartBit) ser[i] = 1'b0;
      if (tx_st[i] == TxDataSend) ser[i] = tx_sh[i][tx_bit[i]];
    end
  end

  // Reference model: byte queue, sticky flag and a "frame open" flag per queue.
  int         depth  [2] = '{16, 4};
  logic [7:0] mbuf   [2][32];
  int         mhead  [2] = '{0, 0};
  int         msize  [2] = '{0, 0};
  logic       m_ovf  [2] = '{1'b0, 1'b0};
  logic       m_start[2] = '{1'b0, 1'b0};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};
  logic       m_open [2] = '{1'b0, 1'b0};
  logic [7:0] lbuf   [2][64];
  int         lhead  [2] = '{0, 0};
  int         lcnt   [2] = '{0, 0};
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   sz;
      logic launch;
      if (reset) begin
        msize[i] = 0; m_ovf[i] = 1'b0; m_start[i] = 1'b0; m_data[i] = 8'h00; m_open[i] = 1'b0;
      end else begin
        sz     = msize[i];
        // A frame may start once the previous one has reported ready after its pulse.
        launch = !m_open[i] && sz > 0 && tx_rdy[i];
        if (clr_ovf) m_ovf[i] = 1'b0;
        if (wr_en && sz == depth[i]) m_ovf[i] = 1'b1;
        if (launch) begin
          m_data[i] = mbuf[i][mhead[i]];
          mhead[i]  = (mhead[i] + 1) % 32;
          msize[i]  = msize[i] - 1;
          m_open[i] = 1'b1;
          lbuf[i][(lhead[i] + lcnt[i]) % 64] = m_data[i];
          lcnt[i]   = lcnt[i] + 1;
        end else if (m_open[i] && !m_start[i] && tx_rdy[i]) begin
          m_open[i] = 1'b0;
        end
        if (wr_en && sz < depth[i]) begin
          mbuf[i][(mhead[i] + msize[i]) % 32] = data_in;
          msize[i] = msize[i] + 1;
        end
        m_start[i] = launch;
      end
    end
    if (reset) m_valid = 1'b1;
  end

  // Per-cycle compare of both queues, plus serial-line reception.
  logic       prev_start[2] = '{1'b0, 1'b0};
  logic [7:0] rx_acc    [2];
  logic [7:0] rx_log    [2][256];
  int         rx_n      [2] = '{0, 0};

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk("tx_start", i, tx_start_v[i], m_start[i]);
        chk("tx_data", i, tx_dat[i], m_data[i]);
        chk("count", i, cnt[i], msize[i]);
        chk("fifo_empty", i, empty_v[i], msize[i] == 0);
        chk("fifo_full", i, full_v[i], msize[i] == depth[i]);
        chk("overflow", i, ovf_v[i], m_ovf[i]);
        chk("busy", i, busy_v[i], m_open[i] || msize[i] != 0);
        chk("start_back_to_back", i, prev_start[i] & tx_start_v[i], 1'b0);
        prev_start[i] = tx_start_v[i];
        if (tx_st[i] == TxStartBit) chk("start_bit", i, ser[i], 1'b0);
        if (tx_st[i] == TxDataSend) rx_acc[i][tx_bit[i]] = ser[i];
        if (tx_st[i] == TxStopBit) begin
          chk("stop_bit", i, ser[i], 1'b1);
          if (lcnt[i] > 0) begin
            chk("rx_byte", i, rx_acc[i], lbuf[i][lhead[i]]);
            lhead[i] = (lhead[i] + 1) % 64;
            lcnt[i]  = lcnt[i] - 1;
          end else begin
            chk("rx_unexpected_frame", i, 1, 0);
          end
          rx_log[i][rx_n[i] % 256] = rx_acc[i];
          rx_n[i] = rx_n[i] + 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (t < 400 && !(msize[0] == 0 && msize[1] == 0 && !m_open[0] && !m_open[1] &&
                        tx_st[0] == TxIdle && tx_st[1] == TxIdle)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("drain_timeout", 0, 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, sent, maxc, base0, base1, peak, np;
    int         ptime[8];
    logic [9:0] bits;
    logic       found;
    logic [7:0] ex[6];

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_tx_start", 0, tx_start_v[0], 1'b0);
    chk("rst_tx_data", 0, tx_dat[0], 8'h00);
    chk("rst_count", 0, cnt[0], 0);
    chk("rst_empty", 0, empty_v[0], 1'b1);
    chk("rst_full", 1, full_v[1], 1'b0);
    chk("rst_overflow", 0, ovf_v[0], 1'b0);
    chk("rst_busy", 0, busy_v[0], 1'b0);
    reset = 1'b0;

    // Single byte: pulse two cycles after the write, line 0,1,0,1,0,0,1,0,1,1
    wr_en = 1'b1; data_in = 8'hA5; n = 0; found = 1'b0;
    while (!found && n < 10) begin
      @(negedge clk);
      wr_en = 1'b0;
      n++;
      if (tx_start_v[0] === 1'b1) found = 1'b1;
    end
    chk("t1_latency", 0, n, 2);
    chk("t1_tx_data", 0, tx_dat[0], 8'hA5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bits[k] = ser[0];
      if (k == 0) chk("t1_pulse_width", 0, tx_start_v[0], 1'b0);
    end
    chk("t1_line", 0, bits, 10'h34A);
    @(negedge clk);
    chk("t1_busy_after_stop", 0, busy_v[0], 1'b0);
    wait_idle();

    // Burst: leader 0xEE then 0x01..0x05 while its frame is in flight
    base0 = rx_n[0]; peak = 0; np = 0;
    for (int c = 0; c < 90; c++) begin
      if (c < 6) begin
        wr_en = 1'b1;
        data_in = (c == 0) ? 8'hEE : 8'(c);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (int'(cnt[0]) > peak) peak = int'(cnt[0]);
      if (tx_start_v[0] === 1'b1) begin
        if (np < 8) ptime[np] = c;
        np++;
      end
    end
    wr_en = 1'b0;
    chk("t2_peak_count", 0, peak, 5);
    chk("t2_pulses", 0, np, 6);
    for (int k = 1; k < 6; k++) chk("t2_spacing", k, ptime[k] - ptime[k-1], 12);
    wait_idle();
    ex = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk("t2_frames", 0, rx_n[0] - base0, 6);
    for (int k = 0; k < 6; k++) chk("t2_order", k, rx_log[0][(base0 + k) % 256], ex[k]);

    // Full/overflow on the depth-4 queue with ready held low
    hold = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", 1, ovf_v[1], 1'b0);
    base1 = rx_n[1];
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; data_in = 8'h10 + 8'(k);
      @(negedge clk);
      if (k == 3) begin
        chk("t3_count4", 1, cnt[1], 4);
        chk("t3_full", 1, full_v[1], 1'b1);
        chk("t3_ovf_before", 1, ovf_v[1], 1'b0);
      end
      if (k == 4) chk("t3_ovf_on_5th", 1, ovf_v[1], 1'b1);
    end
    wr_en = 1'b0;
    chk("t3_count_deep", 0, cnt[0], 6);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t3_clr", 1, ovf_v[1], 1'b0);
    clr_ovf = 1'b1; wr_en = 1'b1; data_in = 8'h16;
    @(negedge clk);
    clr_ovf = 1'b0; wr_en = 1'b0;
    chk("t3_set_wins", 1, ovf_v[1], 1'b1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t3_clr_again", 1, ovf_v[1], 1'b0);
    hold = 1'b0;
    wait_idle();
    chk("t3_frames", 1, rx_n[1] - base1, 4);
    for (int k = 0; k < 4; k++) chk("t3_order", k, rx_log[1][(base1 + k) % 256], 8'h10 + 8'(k));

    // Write in the same cycle as a launch with two bytes queued
    hold = 1'b1; wr_en = 1'b1; data_in = 8'h20;
    @(negedge clk);
    data_in = 8'h21;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t4_count_before", 0, cnt[0], 2);
    hold = 1'b0; wr_en = 1'b1; data_in = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t4_launch", 0, tx_start_v[0], 1'b1);
    chk("t4_count", 0, cnt[0], 2);
    chk("t4_count_small", 1, cnt[1], 2);
    chk("t4_empty", 0, empty_v[0], 1'b0);
    chk("t4_full", 1, full_v[1], 1'b0);
    wait_idle();

    // Pointer wrap on the depth-4 queue, at most 3 queued
    base1 = rx_n[1]; sent = 0; maxc = 0;
    for (int c = 0; c < 800 && sent < 20; c++) begin
      if (msize[1] < 3) begin
        wr_en = 1'b1; data_in = 8'h30 + 8'(sent); sent++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (int'(cnt[1]) > maxc) maxc = int'(cnt[1]);
    end
    wr_en = 1'b0;
    chk("t5_sent", 1, sent, 20);
    chk("t5_max_count_le3", 1, maxc <= 3, 1'b1);
    wait_idle();
    chk("t5_frames", 1, rx_n[1] - base1, 20);
    for (int k = 0; k < 20; k++) chk("t5_order", k, rx_log[1][(base1 + k) % 256], 8'h30 + 8'(k));

    // Reset while the transmitter is sending data bits
    base0 = rx_n[0];
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      data_in = (k == 0) ? 8'h5A : ((k == 1) ? 8'h66 : 8'h77);
      @(negedge clk);
    end
    wr_en = 1'b0;
    n = 0;
    while (tx_st[0] != TxDataSend && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_data_send", 0, n < 20, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_count", 0, cnt[0], 0);
    chk("t6_empty", 0, empty_v[0], 1'b1);
    chk("t6_no_start", 0, tx_start_v[0], 1'b0);
    wr_en = 1'b1; data_in = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 40) begin
      if (tx_start_v[0] === 1'b1) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_pulse_seen", 0, found, 1'b1);
    chk("t6_pulse_in_tx_idle", 0, tx_st[0] == TxIdle, 1'b1);
    chk("t6_frame_done_first", 0, rx_n[0] - base0, 1);
    chk("t6_frame_intact", 0, rx_log[0][base0 % 256], 8'h5A);
    wait_idle();
    chk("t6_frames", 0, rx_n[0] - base0, 2);
    chk("t6_new_byte", 0, rx_log[0][(base0 + 1) % 256], 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
